eth_tx_framer: RTL and testbench
================================

// Module: eth_tx_framer
// PURPOSE
//  Transmit-side frame builder for the Ethernet MAC datapath. Accepts a payload byte stream
//  with valid/ready/last and emits a complete GMII-style 8-bit frame on tx_data/tx_en:
//  7x preamble, SFD, destination MAC, source MAC, EtherType, payload, zero-pad, CRC-32 FCS.
//  Enforces the inter-frame gap. Sits between the packet buffer and the PHY-facing tx pins.
// PARAMETERS
//  MIN_PAYLOAD  46    payload bytes below this are zero-padded (pad bytes are CRC-covered)
//  MAX_PAYLOAD  1500  payload bytes accepted per frame; excess is dropped (see DRAIN)
//  IFG_BYTES    12    idle cycles with tx_en=0 after the last FCS byte
// PORTS
//  clk          in   1   single clock; all logic on posedge clk
//  reset        in   1   synchronous, active-high
//  mac_address  in   48  source MAC; bits [47:40] sent first
//  dst_mac      in   48  destination MAC; sampled at frame start; [47:40] sent first
//  ethertype    in   16  sampled at frame start; [15:8] sent first
//  s_data       in   8   payload byte
//  s_valid      in   1   s_data valid
//  s_last       in   1   s_data is the final payload byte
//  s_ready      out  1   byte accepted when s_valid & s_ready
//  tx_data      out  8   frame byte to the PHY
//  tx_en        out  1   tx_data valid
//  tx_er        out  1   one-cycle error marker on underrun abort
//  busy         out  1   high in every state except IDLE
//  frame_done   out  1   one-cycle pulse in the cycle after the last FCS byte
//  underrun     out  1   one-cycle pulse when a frame is aborted for lack of data
//  oversize     out  1   one-cycle pulse when MAX_PAYLOAD is reached without s_last
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, CRC = 32'hFFFFFFFF. Reset mid-frame
//   forces tx_en=0 in the next cycle with no tx_er. The partial frame is not resumed.
//  States: IDLE, PREAMBLE, SFD, DST, SRC, TYPE, PAYLOAD, PAD, FCS, DRAIN, IFG.
//  IDLE: s_ready=0. If s_valid=1, latch dst_mac/ethertype and enter PREAMBLE. tx_en rises
//   the next cycle. Frame start does not consume the payload byte.
//  PREAMBLE 7 cycles: 8'h55. SFD 1 cycle: 8'hD5. DST/SRC 6 cycles each. TYPE 2 cycles.
//  PAYLOAD: s_ready=1. Each accepted byte goes out as tx_data in the following cycle.
//   tx_en stays high continuously. An 11-bit payload counter increments per accepted byte.
//   - s_valid=0 in PAYLOAD = underrun: tx_en=0, tx_er=1, and underrun pulse in the next
//     cycle. No FCS is sent. Go to IFG.
//   - s_last accepted: go to PAD if count < MIN_PAYLOAD, else go to FCS.
//   - count reaches MAX_PAYLOAD without s_last: oversize pulse, then FCS.
//     After FCS, DRAIN (s_ready=1, tx_en=0) until s_last is accepted, then IFG.
//  PAD: emit 8'h00 until count == MIN_PAYLOAD.
//  FCS: 4 bytes of ~CRC, LSB byte first. frame_done pulses with the first IFG cycle.
//  CRC-32: reflected poly 32'hEDB88320, init 32'hFFFFFFFF, byte-wise, LSB-first.
//   Covers DST through PAD, excluding preamble/SFD. Re-initialised on entry to PREAMBLE.
//  IFG: tx_en=0 for exactly IFG_BYTES cycles, then IDLE. s_valid is ignored during IFG.
//   Back-to-back frames therefore have exactly IFG_BYTES idle cycles between them.
//  tx_en cycles per good frame = 8 + 14 + max(len, MIN_PAYLOAD) + 4.
//  tx_data is registered, and tx_data=0 whenever tx_en=0.
// STRUCTURE
//  eth_pkg: state enum, ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC_POLY=32'hEDB88320,
//   CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3 (also used by the rx-side checker).
//  Sub-module eth_crc32_d8: combinational next-CRC from (crc_in[31:0], data[7:0]). The
//   framer holds the CRC register. The sub-module is shared with the receive path.
// TESTING
//  1-byte payload 8'hAB -> 72 tx_en cycles, 45 pad bytes of 8'h00, FCS matches reference
//   model, CRC over DST..FCS leaves residue 32'hDEBB20E3.
//  46-byte payload -> no PAD state, 72 tx_en cycles. 1500-byte payload -> 1526 cycles.
//  Two frames offered back-to-back -> exactly 12 cycles of tx_en=0 between them,
//   frame_done pulses twice.
//  s_valid drops at payload byte 10 -> tx_er=1 for 1 cycle, underrun pulse, no FCS,
//   12-cycle IFG, and the next frame is clean.
//  1503-byte packet with MAX_PAYLOAD=1500 -> oversize pulse, 1526 tx_en cycles,
//   3 bytes drained, then IFG.
//  reset asserted during PAYLOAD -> tx_en=0, busy=0 next cycle, and the next frame is correct.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, FSM state encoding and byte helpers
// for the MAC transmit and receive paths.
package eth_pkg;

    localparam int unsigned PAY_CNT_W = 11;
    localparam int unsigned SEQ_W     = 8;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DST,
        ST_SRC,
        ST_TYPE,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } eth_state_e;

    // Byte idx of a MAC address, most significant byte first.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [SEQ_W-1:0] idx);
        logic [47:0] sh;
        sh = mac << (32'(idx) * 32'd8);
        return sh[47:40];
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational byte-wise reflected CRC-32 step, shared by tx framer and rx checker.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: wraps a payload stream with preamble, header,
// zero-pad and FCS onto a GMII-style byte interface, then enforces the IFG.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned MIN_PAYLOAD = 46,
    parameter int unsigned MAX_PAYLOAD = 1500,
    parameter int unsigned IFG_BYTES   = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] mac_address,
    input  logic [47:0] dst_mac,
    input  logic [15:0] ethertype,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        tx_er,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic        oversize
);

    eth_state_e             state_q, state_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [PAY_CNT_W-1:0]   pay_q, pay_d, pay_inc;
    logic [47:0]            dst_q, dst_d;
    logic [15:0]            type_q, type_d;
    logic                   drain_q, drain_d;
    logic [31:0]            crc_q, crc_next;
    logic                   crc_init_c, crc_en_c;
    logic                   fcs_end_q, fcs_end_d;

    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_en_q, tx_en_d, tx_er_q, tx_er_d;
    logic       s_ready_q, s_ready_d, busy_q, busy_d;
    logic       frame_done_q, frame_done_d, underrun_q, underrun_d, oversize_q, oversize_d;

    assign pay_inc = pay_q + PAY_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Sequencing: per-state byte counter and payload length.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        pay_d   = pay_q;
        dst_d   = dst_q;
        type_d  = type_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: if (s_valid) begin
                state_d = ST_PREAMBLE;
                seq_d   = SEQ_W'(1);
                pay_d   = '0;
                dst_d   = dst_mac;
                type_d  = ethertype;
                drain_d = 1'b0;
            end
            ST_PREAMBLE: begin
                seq_d = seq_q + SEQ_W'(1);
                if (seq_q == SEQ_W'(6)) begin state_d = ST_SFD; seq_d = '0; end
            end
            ST_SFD: begin state_d = ST_DST; seq_d = '0; end
            ST_DST, ST_SRC: begin
                seq_d = seq_q + SEQ_W'(1);
                if (seq_q == SEQ_W'(5)) begin
                    state_d = (state_q == ST_DST) ? ST_SRC : ST_TYPE;
                    seq_d   = '0;
                end
            end
            ST_TYPE: begin
                seq_d = seq_q + SEQ_W'(1);
                if (seq_q == SEQ_W'(1)) begin state_d = ST_PAYLOAD; seq_d = '0; end
            end
            ST_PAYLOAD: begin
                if (!s_valid) begin
                    // The error cycle itself counts toward the idle gap.
                    state_d = ST_IFG;
                    seq_d   = SEQ_W'(1);
                end else begin
                    pay_d = pay_inc;
                    if (s_last) begin
                        state_d = (pay_inc < PAY_CNT_W'(MIN_PAYLOAD)) ? ST_PAD : ST_FCS;
                        seq_d   = '0;
                    end else if (pay_inc == PAY_CNT_W'(MAX_PAYLOAD)) begin
                        state_d = ST_FCS;
                        seq_d   = '0;
                        drain_d = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                pay_d = pay_inc;
                if (pay_inc == PAY_CNT_W'(MIN_PAYLOAD)) begin state_d = ST_FCS; seq_d = '0; end
            end
            ST_FCS: begin
                seq_d = seq_q + SEQ_W'(1);
                if (seq_q == SEQ_W'(3)) begin
                    state_d = drain_q ? ST_DRAIN : ST_IFG;
                    seq_d   = '0;
                end
            end
            ST_DRAIN: if (s_valid && s_last) begin state_d = ST_IFG; seq_d = '0; end
            ST_IFG: begin
                seq_d = seq_q + SEQ_W'(1);
                if (seq_q == SEQ_W'(IFG_BYTES - 1)) begin state_d = ST_IDLE; seq_d = '0; end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte emission, CRC control and status pulses, registered below.
    always_comb begin
        logic [31:0] fcs;
        fcs          = ~crc_q;
        tx_data_d    = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        crc_init_c   = 1'b0;
        crc_en_c     = 1'b0;
        underrun_d   = 1'b0;
        oversize_d   = 1'b0;
        fcs_end_d    = 1'b0;
        frame_done_d = fcs_end_q;
        s_ready_d    = (state_d == ST_PAYLOAD) || (state_d == ST_DRAIN);
        busy_d       = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: if (s_valid) begin
                tx_en_d    = 1'b1;
                tx_data_d  = ETH_PREAMBLE;
                crc_init_c = 1'b1;
            end
            ST_PREAMBLE: begin tx_en_d = 1'b1; tx_data_d = ETH_PREAMBLE; end
            ST_SFD:      begin tx_en_d = 1'b1; tx_data_d = ETH_SFD; end
            ST_DST: begin tx_en_d = 1'b1; crc_en_c = 1'b1; tx_data_d = mac_byte(dst_q, seq_q); end
            ST_SRC: begin tx_en_d = 1'b1; crc_en_c = 1'b1; tx_data_d = mac_byte(mac_address, seq_q); end
            ST_TYPE: begin
                tx_en_d   = 1'b1;
                crc_en_c  = 1'b1;
                tx_data_d = (seq_q == '0) ? type_q[15:8] : type_q[7:0];
            end
            ST_PAYLOAD: begin
                if (s_valid) begin
                    tx_en_d    = 1'b1;
                    crc_en_c   = 1'b1;
                    tx_data_d  = s_data;
                    oversize_d = !s_last && (pay_inc == PAY_CNT_W'(MAX_PAYLOAD));
                end else begin
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                end
            end
            ST_PAD: begin tx_en_d = 1'b1; crc_en_c = 1'b1; end
            ST_FCS: begin
                tx_en_d   = 1'b1;
                tx_data_d = 8'(fcs >> {seq_q[1:0], 3'b000});
                fcs_end_d = (seq_q == SEQ_W'(3));
            end
            default: ;
        endcase
    end

    eth_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (tx_data_d),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q        <= '0;
            pay_q        <= '0;
            dst_q        <= '0;
            type_q       <= '0;
            drain_q      <= 1'b0;
            crc_q        <= CRC_INIT;
            fcs_end_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            oversize_q   <= 1'b0;
        end else begin
            seq_q        <= seq_d;
            pay_q        <= pay_d;
            dst_q        <= dst_d;
            type_q       <= type_d;
            drain_q      <= drain_d;
            fcs_end_q    <= fcs_end_d;
            if (crc_init_c)    crc_q <= CRC_INIT;
            else if (crc_en_c) crc_q <= crc_next;
            tx_data_q    <= tx_data_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            oversize_q   <= oversize_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_en      = tx_en_q;
    assign tx_er      = tx_er_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign oversize   = oversize_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: expected frame bytes are queued as the
// payload is handed over and checked against tx_data as it leaves the framer.
module tb_eth_tx_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] mac_address = 48'h02_00_5E_10_20_30;
    logic [47:0] dst_mac = '0;
    logic [15:0] ethertype = '0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready, tx_en, tx_er, busy, frame_done, underrun, oversize;
    logic [7:0]  tx_data;

    eth_tx_framer dut (
        .clk         (clk),
        .reset       (reset),
        .mac_address (mac_address),
        .dst_mac     (dst_mac),
        .ethertype   (ethertype),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .tx_er       (tx_er),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun),
        .oversize    (oversize)
    );

    always #5 clk = ~clk;

    localparam int MAXP = 1500;
    localparam int MINP = 46;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  cap[$];
    logic [31:0] frm_crc;

    int run_len = 0, last_run = 0, gap_len = 0, last_gap = 0;
    int n_done = 0, n_under = 0, n_over = 0, n_er = 0;
    logic prev_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic push_crc(input logic [7:0] b);
        exp_q.push_back(b);
        frm_crc = crc_byte(frm_crc, b);
    endtask

    task automatic start_frame(input logic [47:0] dst, input logic [15:0] typ);
        logic [47:0] d;
        logic [47:0] s;
        d = dst;
        s = mac_address;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        frm_crc = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) begin push_crc(d[47:40]); d = d << 8; end
        for (int i = 0; i < 6; i++) begin push_crc(s[47:40]); s = s << 8; end
        push_crc(typ[15:8]);
        push_crc(typ[7:0]);
    endtask

    task automatic finish_frame(input int n);
        logic [31:0] f;
        for (int i = n; i < MINP; i++) push_crc(8'h00);
        f = ~frm_crc;
        for (int i = 0; i < 4; i++) begin exp_q.push_back(f[7:0]); f = f >> 8; end
    endtask

    // Output monitor: scoreboard pop plus run/gap/pulse bookkeeping.
    always @(negedge clk) begin
        logic [8:0] e;
        if (tx_en) begin
            e = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            chk("tx_data", 32'(tx_data), 32'(e));
            cap.push_back(tx_data);
            run_len++;
            if (!prev_en) last_gap = gap_len;
            gap_len = 0;
        end else begin
            chk("idle_data_zero", 32'(tx_data), 32'd0);
            if (prev_en) last_run = run_len;
            run_len = 0;
            gap_len++;
        end
        prev_en = tx_en;
        n_done  += int'(frame_done);
        n_under += int'(underrun);
        n_over  += int'(oversize);
        n_er    += int'(tx_er);
    end

    // Called and returns at a negedge; leaves the stream inputs driven.
    task automatic send_pkt(input int len, input int drop_at, input int rst_at,
                            input logic [7:0] seed, input logic [47:0] dst,
                            input logic [15:0] typ, output int acc);
        int   idx;
        int   cyc;
        logic fire;
        idx = 0;
        cyc = 0;
        dst_mac   = dst;
        ethertype = typ;
        start_frame(dst, typ);
        while (idx < len) begin
            if (cyc > len * 3 + 200) begin
                chk("send_timeout", 32'(idx), 32'(len));
                break;
            end
            if (idx == drop_at) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(posedge clk);
                @(negedge clk);
                break;
            end
            if (idx == rst_at) begin
                reset   = 1'b1;
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("rst_tx_en", 32'(tx_en), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_tx_er", 32'(tx_er), 32'd0);
                reset = 1'b0;
                exp_q.delete();
                break;
            end
            s_valid = 1'b1;
            s_data  = 8'(seed + 8'(idx * 13));
            s_last  = (idx == len - 1);
            fire    = s_ready;
            @(posedge clk);
            if (fire) begin
                if (idx < MAXP) push_crc(s_data);
                idx++;
                if (idx == len && idx <= MAXP)      finish_frame(idx);
                else if (idx == MAXP && len > MAXP) finish_frame(MAXP);
            end
            @(negedge clk);
            cyc++;
        end
        acc = idx;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || tx_en) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int          acc;
        int          d0, u0, o0, e0;
        logic [31:0] c;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'({tx_en, tx_er, busy, s_ready, frame_done, underrun, oversize, tx_data}), 32'd0);

        // 1-byte payload: full padding, FCS and residue.
        cap.delete();
        d0 = n_done;
        send_pkt(1, -1, -1, 8'hAB, 48'hFF_FF_FF_FF_FF_FF, 16'h0800, acc);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle();
        chk("short_run", 32'(last_run), 32'd72);
        chk("short_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("short_done", 32'(n_done - d0), 32'd1);
        chk("short_cap_len", 32'(cap.size()), 32'd72);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < cap.size(); i++) c = crc_byte(c, cap[i]);
        chk("short_residue", c, 32'hDEBB20E3);

        // Exactly minimum length: no padding.
        send_pkt(46, -1, -1, 8'h11, 48'h00_11_22_33_44_55, 16'h88B5, acc);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle();
        chk("min_run", 32'(last_run), 32'd72);
        chk("min_sb_empty", 32'(exp_q.size()), 32'd0);

        // Maximum length with s_last on the final byte.
        o0 = n_over;
        send_pkt(1500, -1, -1, 8'h3C, 48'hA1_B2_C3_D4_E5_F6, 16'h86DD, acc);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle();
        chk("max_run", 32'(last_run), 32'd1526);
        chk("max_no_oversize", 32'(n_over - o0), 32'd0);

        // Back-to-back frames.
        d0 = n_done;
        send_pkt(20, -1, -1, 8'h40, 48'h01_02_03_04_05_06, 16'h0806, acc);
        send_pkt(50, -1, -1, 8'h90, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, acc);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle();
        chk("b2b_gap", 32'(last_gap), 32'd12);
        chk("b2b_done", 32'(n_done - d0), 32'd2);
        chk("b2b_run2", 32'(last_run), 32'd76);
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Underrun after 10 payload bytes, then a clean frame.
        d0 = n_done; u0 = n_under; e0 = n_er;
        send_pkt(30, 10, -1, 8'h27, 48'h12_34_56_78_9A_BC, 16'h0800, acc);
        chk("ur_accepted", 32'(acc), 32'd10);
        send_pkt(8, -1, -1, 8'h5A, 48'hCA_FE_BA_BE_00_01, 16'h0800, acc);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle();
        chk("ur_pulse", 32'(n_under - u0), 32'd1);
        chk("ur_tx_er", 32'(n_er - e0), 32'd1);
        chk("ur_gap", 32'(last_gap), 32'd12);
        chk("ur_next_run", 32'(last_run), 32'd72);
        chk("ur_done", 32'(n_done - d0), 32'd1);
        chk("ur_sb_empty", 32'(exp_q.size()), 32'd0);

        // Oversize packet: truncated at MAX_PAYLOAD, tail drained.
        o0 = n_over; u0 = n_under;
        send_pkt(1503, -1, -1, 8'h77, 48'h66_55_44_33_22_11, 16'h8100, acc);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle();
        chk("ovs_accepted", 32'(acc), 32'd1503);
        chk("ovs_pulse", 32'(n_over - o0), 32'd1);
        chk("ovs_run", 32'(last_run), 32'd1526);
        chk("ovs_no_underrun", 32'(n_under - u0), 32'd0);
        chk("ovs_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the payload, then a clean frame.
        send_pkt(60, -1, 5, 8'h01, 48'hDE_AD_BE_EF_00_02, 16'h0800, acc);
        d0 = n_done;
        send_pkt(20, -1, -1, 8'hC3, 48'hDE_AD_BE_EF_00_03, 16'h0800, acc);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle();
        chk("post_rst_run", 32'(last_run), 32'd72);
        chk("post_rst_done", 32'(n_done - d0), 32'd1);
        chk("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
